inst_fetch: RTL and testbench

//  Instruction fetch stage: the reader side of the 8-bit instruction ROM. Drives the
//  ROM address from an internal program counter and registers the combinational ROM

---
 rtl/inst_fetch.sv | 92 +++++++++
 tb/tb_inst_fetch.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: PC, one-entry instruction buffer, branch redirect, halt
module inst_fetch #(
  parameter int              AW      = 8,
  parameter int              DW      = 8,
  parameter logic [DW-1:0]   HALT_OP = 8'h88,
  parameter int              CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [AW-1:0]    start_addr_i,
  output logic [AW-1:0]    rom_addr_o,
  input  logic [DW-1:0]    rom_data_i,
  output logic [DW-1:0]    inst_o,
  output logic [AW-1:0]    pc_o,
  output logic             inst_valid_o,
  input  logic             inst_ready_i,
  input  logic             branch_i,
  input  logic             branch_back_i,
  input  logic [AW-1:0]    branch_pc_i,
  input  logic [AW-1:0]    branch_off_i,
  output logic             busy_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] inst_count_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]    state;
  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] target;
  logic          xfer;

  assign xfer       = inst_valid_o & inst_ready_i;
  assign busy_o     = (state == S_FETCH) || (state == S_DRAIN);
  assign rom_addr_o = fetch_pc;
  assign target     = branch_back_i ? (branch_pc_i + AW'(1) - branch_off_i)
                                    : (branch_pc_i + AW'(1) + branch_off_i);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      fetch_pc     <= '0;
      inst_o       <= '0;
      pc_o         <= '0;
      inst_valid_o <= 1'b0;
      halted_o     <= 1'b0;
      inst_count_o <= '0;
    end else begin
      if (xfer && (inst_count_o != {CNT_W{1'b1}}))
        inst_count_o <= inst_count_o + CNT_W'(1);

      case (state)
        S_IDLE, S_HALT: begin
          if (start_i) begin
            state        <= S_FETCH;
            fetch_pc     <= start_addr_i;
            inst_valid_o <= 1'b0;
            halted_o     <= 1'b0;
            inst_count_o <= '0;
          end
        end
        S_FETCH, S_DRAIN: begin
          // A redirect flushes the buffer and overrides both capture and a pending halt.
          if (branch_i) begin
            fetch_pc     <= target;
            inst_valid_o <= 1'b0;
            state        <= S_FETCH;
          end else if (state == S_FETCH) begin
            if (!inst_valid_o || xfer) begin
              inst_o       <= rom_data_i;
              pc_o         <= fetch_pc;
              inst_valid_o <= 1'b1;
              if (rom_data_i == HALT_OP)
                state <= S_DRAIN;
              else
                fetch_pc <= fetch_pc + AW'(1);
            end
          end else if (xfer) begin
            state        <= S_HALT;
            halted_o     <= 1'b1;
            inst_valid_o <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch: directed scenarios plus randomized stream model
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [7:0]  start_addr_i;
  logic [7:0]  rom_addr_o;
  logic [7:0]  rom_data_i;
  logic [7:0]  inst_o;
  logic [7:0]  pc_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic        branch_i;
  logic        branch_back_i;
  logic [7:0]  branch_pc_i;
  logic [7:0]  branch_off_i;
  logic        busy_o;
  logic        halted_o;
  logic [15:0] inst_count_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] rom [256];
  assign rom_data_i = rom[rom_addr_o];

  // Stream-level model: which PC the next accepted instruction must come from.
  logic        m_running;
  logic        m_halted;
  logic [15:0] m_count;
  logic [7:0]  m_next_pc;

  inst_fetch dut (
    .clk(clk), .reset(reset), .start_i(start_i), .start_addr_i(start_addr_i),
    .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i), .inst_o(inst_o), .pc_o(pc_o),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .branch_i(branch_i),
    .branch_back_i(branch_back_i), .branch_pc_i(branch_pc_i), .branch_off_i(branch_off_i),
    .busy_o(busy_o), .halted_o(halted_o), .inst_count_o(inst_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_running = 1'b0;
    m_halted  = 1'b0;
    m_count   = '0;
    m_next_pc = '0;
  endtask

  // Account for the current cycle's inputs, advance one clock, then check the model.
  task automatic cycle();
    logic       was_running;
    logic [7:0] tgt;
    was_running = m_running;
    if (inst_valid_o) check("buf_matches_rom", inst_o, rom[pc_o]);
    if (inst_valid_o && inst_ready_i) begin
      check("xfer_pc_order", pc_o, m_next_pc);
      if (m_count != 16'hffff) m_count++;
      m_next_pc = pc_o + 8'd1;
      if (inst_o == 8'h88 && !branch_i) begin
        m_running = 1'b0;
        m_halted  = 1'b1;
      end
    end
    if (branch_i && was_running) begin
      tgt = branch_back_i ? (branch_pc_i + 8'd1 - branch_off_i) : (branch_pc_i + 8'd1 + branch_off_i);
      m_next_pc = tgt;
    end
    if (start_i && !was_running) begin
      m_running = 1'b1;
      m_halted  = 1'b0;
      m_count   = '0;
      m_next_pc = start_addr_i;
    end
    @(posedge clk);
    #1;
    check("count", inst_count_o, m_count);
    check("halted", halted_o, m_halted);
    check("busy", busy_o, m_running);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, inst_valid_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_halted"}, halted_o, 0);
    check({tag, "_count"}, inst_count_o, 0);
    check({tag, "_inst"}, inst_o, 0);
    check({tag, "_pc"}, pc_o, 0);
    check({tag, "_romaddr"}, rom_addr_o, 0);
  endtask

  logic [7:0] t1_inst [4];

  initial begin
    reset = 1'b1; start_i = 0; start_addr_i = 0; inst_ready_i = 0;
    branch_i = 0; branch_back_i = 0; branch_pc_i = 0; branch_off_i = 0;
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'($urandom_range(0, 255));
      if (rom[i] == 8'h88) rom[i] = 8'h00;
    end
    rom[0] = 8'hC1; rom[1] = 8'h90; rom[2] = 8'hC2; rom[3] = 8'h92;
    rom[5] = 8'h4F; rom[92] = 8'h88;
    t1_inst[0] = 8'hC1; t1_inst[1] = 8'h90; t1_inst[2] = 8'hC2; t1_inst[3] = 8'h92;
    model_clear();

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;
    cycle();
    check("idle_no_valid", inst_valid_o, 0);

    // 1: start at 0, one instruction per cycle
    inst_ready_i = 1; start_addr_i = 8'd0; start_i = 1;
    cycle();
    start_i = 0;
    check("t1_romaddr", rom_addr_o, 0);
    check("t1_first_not_yet_valid", inst_valid_o, 0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t1_valid", inst_valid_o, 1);
      check("t1_pc", pc_o, i);
      check("t1_inst", inst_o, t1_inst[i]);
    end

    // 2: backpressure at pc 5
    cycle();
    cycle();
    check("t2_pc5", pc_o, 5);
    inst_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      check("t2_hold_inst", inst_o, 8'h4F);
      check("t2_hold_pc", pc_o, 5);
      check("t2_hold_romaddr", rom_addr_o, 6);
      check("t2_hold_valid", inst_valid_o, 1);
      cycle();
    end
    inst_ready_i = 1;
    check("t2_still_pc5", pc_o, 5);
    cycle();
    check("t2_pc6", pc_o, 6);
    cycle();
    check("t2_pc7", pc_o, 7);
    check("t2_count", inst_count_o, 7);

    // 3: branches, including simultaneous branch + transfer
    branch_i = 1; branch_back_i = 0; branch_pc_i = 8'd119; branch_off_i = 8'd10;
    cycle();
    branch_i = 0;
    check("t3_flush", inst_valid_o, 0);
    check("t3_count_once", inst_count_o, 8);
    cycle();
    check("t3_fwd_valid", inst_valid_o, 1);
    check("t3_fwd_pc", pc_o, 130);
    inst_ready_i = 0;
    branch_i = 1; branch_back_i = 1; branch_pc_i = 8'd126; branch_off_i = 8'd25;
    cycle();
    branch_i = 0;
    check("t3_back_flush", inst_valid_o, 0);
    check("t3_back_count", inst_count_o, 8);
    cycle();
    check("t3_back_pc", pc_o, 102);
    inst_ready_i = 1;
    branch_i = 1; branch_back_i = 0; branch_pc_i = 8'd250; branch_off_i = 8'd10;
    cycle();
    branch_i = 0;
    check("t3_wrap_count", inst_count_o, 9);
    cycle();
    check("t3_wrap_pc", pc_o, 5);
    check("t3_wrap_inst", inst_o, 8'h4F);

    // 6: asynchronous reset between edges
    reset = 1'b1;
    #2;
    check_reset_outputs("async");
    model_clear();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t6_idle_valid", inst_valid_o, 0);
      check("t6_idle_romaddr", rom_addr_o, 0);
    end

    // 4: halt word, drain, restart
    inst_ready_i = 0; start_addr_i = 8'd92; start_i = 1;
    cycle();
    start_i = 0;
    check("t4_romaddr", rom_addr_o, 92);
    cycle();
    check("t4_valid", inst_valid_o, 1);
    check("t4_inst", inst_o, 8'h88);
    check("t4_pc", pc_o, 92);
    cycle();
    check("t4_pc_not_advanced", rom_addr_o, 92);
    inst_ready_i = 1;
    cycle();
    check("t4_halted", halted_o, 1);
    check("t4_valid_drop", inst_valid_o, 0);
    check("t4_count", inst_count_o, 1);
    cycle();
    check("t4_stays_halted", inst_valid_o, 0);
    start_addr_i = 8'd93; start_i = 1;
    cycle();
    start_i = 0;
    check("t4_restart_halted", halted_o, 0);
    cycle();
    check("t4_restart_pc", pc_o, 93);

    // 5: halt captured under backpressure, cancelled by a backward branch
    inst_ready_i = 0;
    branch_i = 1; branch_back_i = 0; branch_pc_i = 8'd91; branch_off_i = 8'd0;
    cycle();
    branch_i = 0;
    cycle();
    check("t5_halt_buffered", inst_o, 8'h88);
    branch_i = 1; branch_back_i = 1; branch_pc_i = 8'd91; branch_off_i = 8'd3;
    cycle();
    branch_i = 0;
    check("t5_not_halted", halted_o, 0);
    cycle();
    check("t5_pc", pc_o, 89);
    check("t5_busy", busy_o, 1);

    // Randomized phase with a few extra halt words
    reset = 1'b1;
    #2;
    model_clear();
    for (int i = 0; i < 4; i++) rom[$urandom_range(0, 255)] = 8'h88;
    reset = 1'b0;
    #1;
    for (int n = 0; n < 4000; n++) begin
      inst_ready_i  = ($urandom_range(0, 9) < 7);
      branch_i      = ($urandom_range(0, 19) == 0);
      branch_back_i = 1'($urandom_range(0, 1));
      branch_pc_i   = 8'($urandom_range(0, 255));
      branch_off_i  = 8'($urandom_range(0, 255));
      start_i       = ($urandom_range(0, 7) == 0);
      start_addr_i  = 8'($urandom_range(0, 255));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
